// File: rtl/ofm_readback_if.sv
// Output element stream of the OFM readback block.
// Master drives data/valid/last; slave drives ready.
interface ofm_readback_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/ofm_readback.sv
// Streams the final-layer OFM out of the OFM RAM as DATA_WIDTH elements.
// Optional running checksum enabled by defining OFM_RDBK_CHECKSUM_EN.
module ofm_readback #(
    parameter int DATA_WIDTH   = 64,
    parameter int INOUT_WIDTH  = 1024,
    parameter int OFM_RAM_SIZE = 2378675,
    parameter int BASE_ADDR    = 526912,
    parameter int NUM_ELEM     = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            ram_rd_en,
    output logic [$clog2(OFM_RAM_SIZE)-1:0] ram_rd_addr,
    input  logic [INOUT_WIDTH-1:0]          ram_rd_data,
    ofm_readback_if.master                  m,
    output logic [DATA_WIDTH-1:0]           checksum
);
    localparam int LANES = INOUT_WIDTH / DATA_WIDTH;
    localparam int AW    = $clog2(OFM_RAM_SIZE);
    localparam int LW    = $clog2(LANES);
    localparam int CW    = $clog2(NUM_ELEM + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        STREAM,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CW-1:0]          elem_cnt;
    logic [LW-1:0]          lane;
    logic [AW-1:0]          line_addr;
    logic [INOUT_WIDTH-1:0] line_q;
    logic                   hs;
    logic                   is_last;
    logic                   lane_end;

    assign hs       = (state == STREAM) && m.m_ready;
    assign is_last  = (elem_cnt == CW'(NUM_ELEM - 1));
    assign lane_end = (lane == LW'(LANES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            elem_cnt  <= '0;
            lane      <= '0;
            line_addr <= AW'(BASE_ADDR);
            line_q    <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    elem_cnt  <= '0;
                    line_addr <= AW'(BASE_ADDR);
                end
                WAIT: begin
                    line_q <= ram_rd_data;
                    lane   <= '0;
                end
                STREAM: begin
                    if (hs) begin
                        elem_cnt <= elem_cnt + CW'(1);
                        lane     <= lane + LW'(1);
                        if (lane_end && !is_last)
                            line_addr <= line_addr + AW'(LANES);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (start) state_nxt = READ;
            READ:   state_nxt = WAIT;
            WAIT:   state_nxt = STREAM;
            STREAM: begin
                if (hs) begin
                    if (is_last)
                        state_nxt = DONE;
                    else if (lane_end)
                        state_nxt = READ;
                end
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are pure state decodes so a reset zeroes them on the next cycle.
    assign busy        = (state == READ) || (state == WAIT) || (state == STREAM);
    assign done        = (state == DONE);
    assign ram_rd_en   = (state == READ);
    assign ram_rd_addr = ram_rd_en ? line_addr : '0;
    assign m.m_valid   = (state == STREAM);
    assign m.m_last    = (state == STREAM) && is_last;
    assign m.m_data    = (state == STREAM) ?
                         line_q[lane*DATA_WIDTH +: DATA_WIDTH] : '0;

`ifdef OFM_RDBK_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;

    always_ff @(posedge clk) begin
        if (!rst_n)
            csum <= '0;
        else if ((state == IDLE) && start)
            csum <= '0;
        else if (hs)
            csum <= csum + m.m_data;
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_ofm_readback.sv
// Randomised self-checking bench for ofm_readback.
// Reference: element i of the stream equals RAM element BASE_ADDR+i.
module tb_ofm_readback;
    localparam int DW = 64;
    localparam int IW = 1024;
    localparam int RS = 2378675;
    localparam int BA = 526912;
    localparam int N  = 256;
    localparam int N2 = 20;
    localparam int LN = IW / DW;
    localparam int AW = $clog2(RS);

    logic clk = 0;
    logic rst_n = 0;
    logic start = 0;
    logic start2 = 0;
    always #5 clk = ~clk;

    ofm_readback_if #(.DATA_WIDTH(DW)) s1 ();
    ofm_readback_if #(.DATA_WIDTH(DW)) s2 ();

    logic          busy, done, rd_en;
    logic          busy2, done2, rd_en2;
    logic [AW-1:0] rd_addr, rd_addr2;
    logic [IW-1:0] rd_data, rd_data2;
    logic [DW-1:0] csum, csum2;

    ofm_readback #(
        .DATA_WIDTH(DW), .INOUT_WIDTH(IW), .OFM_RAM_SIZE(RS),
        .BASE_ADDR(BA), .NUM_ELEM(N)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .done(done), .ram_rd_en(rd_en), .ram_rd_addr(rd_addr),
        .ram_rd_data(rd_data), .m(s1), .checksum(csum)
    );

    ofm_readback #(
        .DATA_WIDTH(DW), .INOUT_WIDTH(IW), .OFM_RAM_SIZE(RS),
        .BASE_ADDR(BA), .NUM_ELEM(N2)
    ) u_dut20 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2),
        .done(done2), .ram_rd_en(rd_en2), .ram_rd_addr(rd_addr2),
        .ram_rd_data(rd_data2), .m(s2), .checksum(csum2)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RAM model: element memory around BASE_ADDR, junk on idle cycles
    logic [63:0] mem [0:N+LN-1];

    function automatic logic [IW-1:0] line_of(input logic [AW-1:0] a);
        logic [IW-1:0] l;
        int idx;
        l = '0;
        for (int k = 0; k < LN; k++) begin
            idx = int'(a) - BA + k;
            if (idx >= 0 && idx < N + LN) l[k*DW +: DW] = mem[idx];
        end
        return l;
    endfunction

    function automatic logic [IW-1:0] junk();
        logic [IW-1:0] j;
        for (int k = 0; k < IW / 32; k++) j[k*32 +: 32] = $urandom;
        return j;
    endfunction

    always @(posedge clk) begin
        rd_data  <= rd_en  ? line_of(rd_addr)  : junk();
        rd_data2 <= rd_en2 ? line_of(rd_addr2) : junk();
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record handshakes, reads and done pulses
    logic [63:0]   got_q[$];
    logic [63:0]   got2_q[$];
    int            hs_cyc_q[$];
    int            last_q[$];
    int            last2_q[$];
    int            rd_cyc_q[$];
    logic [AW-1:0] rd_q[$];
    logic [AW-1:0] rd2_q[$];
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            done2_cnt = 0;
    logic          pv = 0;
    logic          pl = 0;
    logic [63:0]   pd = 0;

    always @(negedge clk) begin
        if (pv) begin
            chk("stall_valid", 64'(s1.m_valid), 1);
            chk("stall_data", s1.m_data, pd);
            chk("stall_last", 64'(s1.m_last), 64'(pl));
        end
        pv = s1.m_valid && !s1.m_ready;
        pd = s1.m_data;
        pl = s1.m_last;
        if (rd_en) begin
            rd_q.push_back(rd_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (s1.m_valid && s1.m_ready) begin
            if (s1.m_last) last_q.push_back(got_q.size());
            got_q.push_back(s1.m_data);
            hs_cyc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_busy", 64'(busy), 0);
        end
        if (rd_en2) rd2_q.push_back(rd_addr2);
        if (s2.m_valid && s2.m_ready) begin
            if (s2.m_last) last2_q.push_back(got2_q.size());
            got2_q.push_back(s2.m_data);
        end
        if (done2) done2_cnt++;
    end

    task automatic pulse_start(output int t);
        @(posedge clk);
        #1 start = 1;
        t = cyc;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done(input int d0, input int bound, input bit rnd);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk);
            #1 if (rnd) s1.m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done_cnt > d0) ok = 1;
        end
        if (!ok) chk("done_timeout", 0, 1);
        s1.m_ready = 1;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_elems(input int g0, input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (got_q.size() - g0 >= n) ok = 1;
        end
        if (!ok) chk("elem_timeout", 0, 1);
    endtask

    task automatic verify_stream(input int g0, input int l0, input int r0);
        int n;
        n = got_q.size() - g0;
        chk("elem_count", n, N);
        for (int i = 0; i < N && i < n; i++)
            chk($sformatf("elem[%0d]", i), got_q[g0+i], mem[i]);
        chk("last_count", last_q.size() - l0, 1);
        if (last_q.size() > l0) chk("last_idx", last_q[l0] - g0, N - 1);
        chk("read_count", rd_q.size() - r0, N / LN);
        for (int k = 0; k < N / LN && r0 + k < rd_q.size(); k++)
            chk($sformatf("rd_addr[%0d]", k), rd_q[r0+k], BA + k * LN);
    endtask

    function automatic logic [63:0] exp_sum();
        logic [63:0] s;
        s = 0;
        for (int i = 0; i < N; i++) s += mem[i];
`ifdef OFM_RDBK_CHECKSUM_EN
        return s;
`else
        return 0;
`endif
    endfunction

    int t, g0, l0, r0, d0;

    initial begin
        s1.m_ready = 1;
        s2.m_ready = 1;
        for (int i = 0; i < N + LN; i++) mem[i] = 64'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_rd_en", 64'(rd_en), 0);
        chk("rst_addr", 64'(rd_addr), 0);
        chk("rst_valid", 64'(s1.m_valid), 0);
        chk("rst_last", 64'(s1.m_last), 0);
        chk("rst_data", s1.m_data, 0);
        chk("rst_csum", csum, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // Run A: incrementing data, ready held high
        g0 = got_q.size(); l0 = last_q.size();
        r0 = rd_q.size(); d0 = done_cnt;
        pulse_start(t);
        @(negedge clk);
        chk("a_busy", 64'(busy), 1);
        chk("a_rd_en", 64'(rd_en), 1);
        wait_done(d0, 400, 0);
        verify_stream(g0, l0, r0);
        chk("a_rd_lat", rd_cyc_q[r0], t + 1);
        chk("a_v_lat", hs_cyc_q[g0], t + 3);
        chk("a_span", hs_cyc_q[$] - rd_cyc_q[r0], 16 * 18 - 1);
        chk("a_done_cyc", done_cyc, hs_cyc_q[$] + 1);
        chk("a_done_cnt", done_cnt - d0, 1);
        chk("a_csum", csum, exp_sum());

        // Run B: random data, random backpressure
        for (int i = 0; i < N + LN; i++) mem[i] = {$urandom, $urandom};
        g0 = got_q.size(); l0 = last_q.size();
        r0 = rd_q.size(); d0 = done_cnt;
        pulse_start(t);
        wait_done(d0, 2000, 1);
        verify_stream(g0, l0, r0);
        chk("b_done_cnt", done_cnt - d0, 1);
        chk("b_csum", csum, exp_sum());

        // Run C: start re-pulsed mid-stream is ignored
        g0 = got_q.size(); l0 = last_q.size();
        r0 = rd_q.size(); d0 = done_cnt;
        pulse_start(t);
        wait_elems(g0, 100);
        pulse_start(t);
        wait_done(d0, 400, 0);
        repeat (30) @(negedge clk);
        verify_stream(g0, l0, r0);
        chk("c_done_cnt", done_cnt - d0, 1);
        chk("c_busy", 64'(busy), 0);
        chk("c_csum", csum, exp_sum());

        // Run D: reset mid-stream, then restart from the beginning
        d0 = done_cnt;
        g0 = got_q.size();
        pulse_start(t);
        wait_elems(g0, 50);
        @(posedge clk);
        #1 rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        chk("d_busy", 64'(busy), 0);
        chk("d_done", 64'(done), 0);
        chk("d_rd_en", 64'(rd_en), 0);
        chk("d_addr", 64'(rd_addr), 0);
        chk("d_valid", 64'(s1.m_valid), 0);
        chk("d_last", 64'(s1.m_last), 0);
        chk("d_data", s1.m_data, 0);
        chk("d_csum", csum, 0);
        @(posedge clk);
        #1 rst_n = 1;
        repeat (5) @(negedge clk);
        chk("d_no_done", done_cnt - d0, 0);
        g0 = got_q.size(); l0 = last_q.size();
        r0 = rd_q.size(); d0 = done_cnt;
        pulse_start(t);
        wait_done(d0, 400, 0);
        verify_stream(g0, l0, r0);
        chk("d_csum_end", csum, exp_sum());

        // Run E: NUM_ELEM=20 instance, partial last line
        @(posedge clk);
        #1 start2 = 1;
        @(posedge clk);
        #1 start2 = 0;
        for (int i = 0; i < 200 && done2_cnt == 0; i++) @(negedge clk);
        chk("e_done", done2_cnt, 1);
        chk("e_reads", rd2_q.size(), 2);
        if (rd2_q.size() >= 2) begin
            chk("e_rd0", rd2_q[0], BA);
            chk("e_rd1", rd2_q[1], BA + LN);
        end
        chk("e_count", got2_q.size(), N2);
        for (int i = 0; i < N2 && i < got2_q.size(); i++)
            chk($sformatf("e_elem[%0d]", i), got2_q[i], mem[i]);
        chk("e_last_cnt", last2_q.size(), 1);
        if (last2_q.size() > 0) chk("e_last_idx", last2_q[0], N2 - 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
